lockin_demod: RTL and testbench

LOCKIN_DEMOD -- requirements
Module: lockin_demod

---
 rtl/lockin_if.sv | 12 +
 rtl/lockin_demod.sv | 91 +++++++++
 tb/tb_lockin_demod.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lockin_if.sv
// lockin_if: sample-in / result-out bus of the lock-in demodulator.
interface lockin_if #(parameter int WORD_W = 16);
  logic in_valid;
  logic signed [WORD_W-1:0] adc_in;
  logic signed [WORD_W-1:0] ref_sin;
  logic signed [WORD_W-1:0] ref_cos;
  logic signed [WORD_W-1:0] i_out;
  logic signed [WORD_W-1:0] q_out;
  logic out_valid;
  modport master (output in_valid, adc_in, ref_sin, ref_cos, input i_out, q_out, out_valid);
  modport slave (input in_valid, adc_in, ref_sin, ref_cos, output i_out, q_out, out_valid);
endinterface

// File: rtl/lockin_demod.sv
// lockin_demod: windowed I/Q lock-in demodulator (register, multiply, accumulate).
// Define LOCKIN_SAT_OUT_EN to saturate shifted results instead of wrapping them.
module lockin_demod #(
  parameter int WORD_W = 16,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [CNT_W-1:0] integ_len,
  input  logic [5:0] out_shift,
  output logic busy,
  lockin_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic s1_v, s2_v, c1, c2, done, run, take, last;
  logic [CNT_W-1:0] cnt, len_q, len_eff;
  logic signed [WORD_W-1:0] a_q, s_q, c_q;
  logic signed [2*WORD_W-1:0] p_i, p_q;
  logic signed [ACC_W-1:0] acc_i, acc_q, pe_i, pe_q;

  function automatic logic signed [WORD_W-1:0] fmt(input logic signed [ACC_W-1:0] acc, input logic [5:0] sh);
`ifdef LOCKIN_SAT_OUT_EN
    logic signed [ACC_W-1:0] v, hi;
    v = acc >>> sh;
    hi = v >>> (WORD_W - 1);
    return (hi == '0 || hi == '1) ? WORD_W'(v) :
           v[ACC_W-1] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
`else
    return WORD_W'(acc >>> sh);
`endif
  endfunction

  always_comb begin
    state_d = enable ? RUN : IDLE;
    busy = state == RUN;
    run = busy && enable;
    take = run && bus.in_valid;
    len_eff = len_q == '0 ? CNT_W'(1) : len_q;
    last = cnt + CNT_W'(1) == len_eff;
    pe_i = p_i;
    pe_q = p_q;
  end

  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      {s1_v, s2_v, c1, c2, done} <= '0;
      cnt <= '0;
      len_q <= '0;
      acc_i <= '0;
      acc_q <= '0;
      bus.i_out <= '0;
      bus.q_out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= state_d;
      bus.out_valid <= run && done;
      if (run && done) begin
        bus.i_out <= fmt(acc_i, out_shift);
        bus.q_out <= fmt(acc_q, out_shift);
      end
      if (!run) begin
        {s1_v, s2_v, c1, c2, done} <= '0;
        cnt <= '0;
        len_q <= integ_len;
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        s1_v <= take;
        c1 <= take && last;
        if (take) begin
          a_q <= bus.adc_in;
          s_q <= bus.ref_sin;
          c_q <= bus.ref_cos;
          cnt <= last ? '0 : cnt + CNT_W'(1);
          if (last) len_q <= integ_len;
        end
        s2_v <= s1_v;
        c2 <= c1;
        p_i <= a_q * s_q;
        p_q <= a_q * c_q;
        done <= c2;
        // a finished window is emitted while the next window's first product seeds the accumulator
        acc_i <= (done ? '0 : acc_i) + (s2_v ? pe_i : '0);
        acc_q <= (done ? '0 : acc_q) + (s2_v ? pe_q : '0);
      end
    end
endmodule

// File: tb/tb_lockin_demod.sv
// tb_lockin_demod: directed and random stimulus against a window-sum reference model.
module tb_lockin_demod;
  logic clk = 0, rst = 0, enable = 0;
  logic [31:0] integ_len = 0;
  logic [5:0] out_shift = 0;
  logic busy;
  logic signed [15:0] a = 0, s = 0, c = 0;
  logic vin = 0;
  int vectors = 0, miscompares = 0, n = 0, pulses = 0;

  typedef struct {int t; longint si; longint sq;} ent_t;
  ent_t pend[$];
  bit m_run = 0;
  longint m_len = 0, m_cnt = 0, sum_i = 0, sum_q = 0, exp_i = 0, exp_q = 0;
  bit exp_v = 0;

  lockin_if #(.WORD_W(16)) bus();
  lockin_demod dut (.clk(clk), .rst(rst), .enable(enable), .integ_len(integ_len),
                    .out_shift(out_shift), .busy(busy), .bus(bus.slave));

  always #2 clk = ~clk;

  function automatic longint w48(longint x);
    return (x <<< 16) >>> 16;
  endfunction

  function automatic longint fmt(longint sum, int sh);
    longint v;
    logic signed [15:0] t;
    v = sum >>> sh;
`ifdef LOCKIN_SAT_OUT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = v[15:0];
    return longint'(t);
`endif
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: got %0d want %0d", tag, n, obs, expv);
    end
  endtask

  task automatic tick();
    bus.in_valid = vin;
    bus.adc_in = a;
    bus.ref_sin = s;
    bus.ref_cos = c;
    @(posedge clk);
    n++;
    exp_v = 0;
    if (!rst) begin
      m_run = 0; m_cnt = 0; sum_i = 0; sum_q = 0; exp_i = 0; exp_q = 0;
      pend.delete();
    end else begin
      if (m_run && !enable) begin
        pend.delete(); m_cnt = 0; sum_i = 0; sum_q = 0;
      end else if (pend.size() > 0 && pend[0].t == n) begin
        exp_v = 1;
        exp_i = fmt(pend[0].si, int'(out_shift));
        exp_q = fmt(pend[0].sq, int'(out_shift));
        void'(pend.pop_front());
      end
      if (!m_run && enable) m_len = longint'(integ_len);
      if (m_run && enable && vin) begin
        sum_i = w48(sum_i + longint'(a) * longint'(s));
        sum_q = w48(sum_q + longint'(a) * longint'(c));
        m_cnt++;
        if (m_cnt == (m_len == 0 ? 1 : m_len)) begin
          pend.push_back('{n + 3, sum_i, sum_q});
          sum_i = 0; sum_q = 0; m_cnt = 0;
          m_len = longint'(integ_len);
        end
      end
      m_run = enable;
    end
    #1;
    if (bus.out_valid === 1'b1) pulses++;
    chk("out_valid", longint'(bus.out_valid), longint'(exp_v));
    chk("i_out", longint'(bus.i_out), exp_i);
    chk("q_out", longint'(bus.q_out), exp_q);
    chk("busy", longint'(busy), longint'(m_run));
  endtask

  task automatic run_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    int p0;
    run_n(3);
    rst = 1;
    // basic window: 80000 overflows the 16-bit output
    integ_len = 4; out_shift = 0; a = 100; s = 200; c = -50; enable = 1; vin = 1;
    run_n(13);
`ifdef LOCKIN_SAT_OUT_EN
    chk("basic_i", longint'(bus.i_out), 32767);
`else
    chk("basic_i", longint'(bus.i_out), 14464);
`endif
    chk("basic_q", longint'(bus.q_out), -20000);
    // bubbles
    enable = 0; vin = 0; tick();
    integ_len = 3; out_shift = 8; a = 256; s = 256; c = 0; enable = 1; tick();
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin vin = (i % 2 == 0); tick(); end
    vin = 0;
    run_n(6);
    chk("bubble_pulses", longint'(pulses - p0), 1);
    chk("bubble_i", longint'(bus.i_out), 768);
    // zero length
    enable = 0; tick();
    integ_len = 0; out_shift = 0; a = 1; s = 1; c = 1; enable = 1; tick();
    vin = 1; run_n(8);
    // abort after 2 of 8
    enable = 0; vin = 0; tick();
    integ_len = 8; a = 3; s = -7; c = 11; enable = 1; tick();
    vin = 1; run_n(2);
    enable = 0; tick();
    enable = 1; vin = 0; tick();
    vin = 1; run_n(8);
    vin = 0; run_n(4);
    // mid-window reset
    integ_len = 4; vin = 1; run_n(2);
    rst = 0; tick();
    rst = 1; run_n(10);
    // length change mid-window
    enable = 0; vin = 0; tick();
    integ_len = 4; a = -1234; s = 567; c = 890; enable = 1; tick();
    vin = 1; run_n(2);
    integ_len = 2; run_n(12);
    // random
    for (int i = 0; i < 600; i++) begin
      a = 16'($urandom); s = 16'($urandom); c = 16'($urandom);
      vin = $urandom_range(0, 9) < 7;
      enable = $urandom_range(0, 39) != 0;
      rst = $urandom_range(0, 99) != 0;
      out_shift = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) integ_len = $urandom_range(0, 5);
      tick();
    end
    rst = 1; enable = 1; run_n(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
